ca_code_checker: RTL and testbench

- Receive-side counterpart of the C/A code generator.
- Takes a hard-decision received chip stream and regenerates the selected PRN's C/A sequence locally with G1/G2 LFSRs.
- Counts chip agreements over each 1023-chip epoch and slips the local code phase one chip per failed epoch until agreement reaches threshold (lock) or all 1023 phases are exhausted (fail).
- Sits between the front-end chip slicer and the tracking-channel setup logic; the final code phase seeds the channel's code-shift state.

---
 rtl/ca_code_checker_pkg.sv | 67 ++++++
 rtl/ca_code_checker_if.sv | 27 ++
 rtl/ca_code_checker_lfsr_pair.sv | 42 ++++
 rtl/ca_code_checker.sv | 160 ++++++++++++++++
 tb/tb_ca_code_checker.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ca_code_checker_pkg.sv
// Shared types, constants and the G2 phase-selector table for the C/A code checker.
package ca_code_checker_pkg;

  localparam int CA_LEN = 1023;
  localparam int PRN_W  = 5;
  localparam int CS_W   = 10;

  typedef logic [PRN_W-1:0] prn_t;
  typedef logic [CS_W-1:0]  ca_cs_t;
  typedef logic [10:0]      ca_cnt_t;

  localparam logic [10:1] G_INIT = 10'h3FF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CORR,
    ST_EVAL,
    ST_SLIP,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [3:0] tap_a;
    logic [3:0] tap_b;
  } g2_taps_t;

  // prn is zero-based: 0 selects PRN 1.
  function automatic g2_taps_t ca_g2_taps(input prn_t prn);
    g2_taps_t t;
    case (prn)
      5'd0:  t = '{4'd2, 4'd6};
      5'd1:  t = '{4'd3, 4'd7};
      5'd2:  t = '{4'd4, 4'd8};
      5'd3:  t = '{4'd5, 4'd9};
      5'd4:  t = '{4'd1, 4'd9};
      5'd5:  t = '{4'd2, 4'd10};
      5'd6:  t = '{4'd1, 4'd8};
      5'd7:  t = '{4'd2, 4'd9};
      5'd8:  t = '{4'd3, 4'd10};
      5'd9:  t = '{4'd2, 4'd3};
      5'd10: t = '{4'd3, 4'd4};
      5'd11: t = '{4'd5, 4'd6};
      5'd12: t = '{4'd6, 4'd7};
      5'd13: t = '{4'd7, 4'd8};
      5'd14: t = '{4'd8, 4'd9};
      5'd15: t = '{4'd9, 4'd10};
      5'd16: t = '{4'd1, 4'd4};
      5'd17: t = '{4'd2, 4'd5};
      5'd18: t = '{4'd3, 4'd6};
      5'd19: t = '{4'd4, 4'd7};
      5'd20: t = '{4'd5, 4'd8};
      5'd21: t = '{4'd6, 4'd9};
      5'd22: t = '{4'd1, 4'd3};
      5'd23: t = '{4'd4, 4'd6};
      5'd24: t = '{4'd5, 4'd7};
      5'd25: t = '{4'd6, 4'd8};
      5'd26: t = '{4'd7, 4'd9};
      5'd27: t = '{4'd8, 4'd10};
      5'd28: t = '{4'd1, 4'd6};
      5'd29: t = '{4'd2, 4'd7};
      5'd30: t = '{4'd3, 4'd8};
      default: t = '{4'd4, 4'd9};
    endcase
    return t;
  endfunction

endpackage

// File: rtl/ca_code_checker_if.sv
// Control, chip-stream and result signals between the chip slicer, the checker and channel setup.
interface ca_code_checker_if;
  import ca_code_checker_pkg::*;

  logic    start;
  logic    abort;
  prn_t    prn;
  logic    chip_in;
  logic    chip_valid;
  logic    busy;
  logic    done;
  logic    locked;
  ca_cs_t  code_phase;
  ca_cnt_t match_count;
  logic    polarity;

  modport master (
    output start, abort, prn, chip_in, chip_valid,
    input  busy, done, locked, code_phase, match_count, polarity
  );

  modport slave (
    input  start, abort, prn, chip_in, chip_valid,
    output busy, done, locked, code_phase, match_count, polarity
  );

endinterface

// File: rtl/ca_code_checker_lfsr_pair.sv
// Local C/A replica: G1/G2 shift registers with load-to-3FF and single-step enables.
module ca_code_checker_lfsr_pair
  import ca_code_checker_pkg::*;
(
  input  logic     clk,
  input  logic     reset_n,
  input  logic     load,
  input  logic     step,
  input  g2_taps_t taps,
  output logic     chip
);

  logic [10:1] g1_q, g1_d;
  logic [10:1] g2_q, g2_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    g1_d = g1_q;
    g2_d = g2_q;
    if (load) begin
      g1_d = G_INIT;
      g2_d = G_INIT;
    end else if (step) begin
      g1_d = {g1_q[9:1], g1_q[3] ^ g1_q[10]};
      g2_d = {g2_q[9:1], g2_q[2] ^ g2_q[3] ^ g2_q[6] ^ g2_q[8] ^ g2_q[9] ^ g2_q[10]};
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      g1_q <= G_INIT;
      g2_q <= G_INIT;
    end else begin
      g1_q <= g1_d;
      g2_q <= g2_d;
    end
  end

  assign chip = g1_q[10] ^ g2_q[taps.tap_a] ^ g2_q[taps.tap_b];

endmodule

// File: rtl/ca_code_checker.sv
// C/A code-phase search: correlates received chips per epoch, slipping one chip per failed epoch.
// Optional inverted-sequence lock is enabled by defining CA_CHECKER_INVERT_EN.
module ca_code_checker
  import ca_code_checker_pkg::*;
#(
  parameter logic [10:0] THRESH    = 11'd900,
  parameter logic [9:0]  MAX_PHASE = 10'd1022
) (
  input logic               clk,
  input logic               reset_n,
  ca_code_checker_if.slave  bus
);

  localparam ca_cs_t LAST_CHIP = ca_cs_t'(CA_LEN - 1);
`ifdef CA_CHECKER_INVERT_EN
  localparam ca_cnt_t INV_THRESH = ca_cnt_t'(CA_LEN) - THRESH;
`endif

  state_e  state_q, state_d;
  ca_cs_t  chip_cnt_q, chip_cnt_d;
  ca_cs_t  phase_q, phase_d;
  ca_cnt_t agree_q, agree_d;
  prn_t    prn_q, prn_d;
  ca_cnt_t match_count_q, match_count_d;
  ca_cs_t  code_phase_q, code_phase_d;
  logic    busy_q, busy_d;
  logic    done_q, done_d;
  logic    locked_q, locked_d;
  logic    polarity_q, polarity_d;

  logic lfsr_load, lfsr_step, local_chip, go_done;

  ca_code_checker_lfsr_pair u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (lfsr_load),
    .step    (lfsr_step),
    .taps    (ca_g2_taps(prn_q)),
    .chip    (local_chip)
  );

  always_comb begin
    state_d       = state_q;
    chip_cnt_d    = chip_cnt_q;
    phase_d       = phase_q;
    agree_d       = agree_q;
    prn_d         = prn_q;
    match_count_d = match_count_q;
    code_phase_d  = code_phase_q;
    locked_d      = locked_q;
    polarity_d    = polarity_q;
    lfsr_load     = 1'b0;
    lfsr_step     = 1'b0;
    go_done       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d    = ST_CORR;
          chip_cnt_d = '0;
          agree_d    = '0;
          phase_d    = '0;
          prn_d      = bus.prn;
          locked_d   = 1'b0;
          polarity_d = 1'b0;
          lfsr_load  = 1'b1;
        end
      end
      ST_CORR: begin
        if (bus.abort) begin
          go_done = 1'b1;
        end else if (bus.chip_valid) begin
          agree_d   = agree_q + ca_cnt_t'(bus.chip_in == local_chip);
          lfsr_step = 1'b1;
          if (chip_cnt_q == LAST_CHIP) state_d = ST_EVAL;
          else                         chip_cnt_d = chip_cnt_q + 1'b1;
        end
      end
      ST_EVAL: begin
        if (bus.abort) begin
          go_done = 1'b1;
        end else begin
          match_count_d = agree_q;
          if (agree_q >= THRESH) begin
            locked_d   = 1'b1;
            polarity_d = 1'b0;
            go_done    = 1'b1;
`ifdef CA_CHECKER_INVERT_EN
          end else if (agree_q <= INV_THRESH) begin
            locked_d   = 1'b1;
            polarity_d = 1'b1;
            go_done    = 1'b1;
`endif
          end else if (phase_q == MAX_PHASE) begin
            go_done = 1'b1;
          end else begin
            state_d = ST_SLIP;
          end
        end
      end
      ST_SLIP: begin
        // The extra step advances the replica one chip relative to the incoming stream.
        if (bus.abort) begin
          go_done = 1'b1;
        end else begin
          lfsr_step  = 1'b1;
          phase_d    = phase_q + 1'b1;
          agree_d    = '0;
          chip_cnt_d = '0;
          state_d    = ST_CORR;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (go_done) begin
      state_d      = ST_DONE;
      code_phase_d = phase_q;
    end
    done_d = go_done;
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      chip_cnt_q    <= '0;
      phase_q       <= '0;
      agree_q       <= '0;
      prn_q         <= '0;
      match_count_q <= '0;
      code_phase_q  <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      locked_q      <= 1'b0;
      polarity_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      chip_cnt_q    <= chip_cnt_d;
      phase_q       <= phase_d;
      agree_q       <= agree_d;
      prn_q         <= prn_d;
      match_count_q <= match_count_d;
      code_phase_q  <= code_phase_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      locked_q      <= locked_d;
      polarity_q    <= polarity_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.locked      = locked_q;
  assign bus.code_phase  = code_phase_q;
  assign bus.match_count = match_count_q;
  assign bus.polarity    = polarity_q;

endmodule

// File: tb/tb_ca_code_checker.sv
// Scoreboard bench for ca_code_checker: expected search results queued per scenario, compared on done.
module tb_ca_code_checker;
  import ca_code_checker_pkg::*;

  localparam logic [10:0] TB_THRESH    = 11'd900;
  localparam logic [9:0]  TB_MAX_PHASE = 10'd7;

  localparam int TAP_A [32] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4};
  localparam int TAP_B [32] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9};

  typedef struct packed {
    logic          locked;
    logic [9:0]    code_phase;
    logic [10:0]   match_count;
    logic          polarity;
  } result_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ca_code_checker_if bus ();

  ca_code_checker #(.THRESH(TB_THRESH), .MAX_PHASE(TB_MAX_PHASE)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  result_t exp_q[$];
  result_t obs_q[$];
  int checks = 0;
  int errors = 0;
  logic [0:1022] code1, code2, code10;

  always @(negedge clk)
    if (reset_n && bus.done)
      obs_q.push_back(result_t'{bus.locked, bus.code_phase, bus.match_count, bus.polarity});

  // Reference C/A generator, stage-by-stage as in the GPS interface description.
  function automatic logic [0:1022] gen_code(input int p);
    bit g1 [1:10];
    bit g2 [1:10];
    bit f1, f2;
    logic [0:1022] c;
    for (int s = 1; s <= 10; s++) begin g1[s] = 1'b1; g2[s] = 1'b1; end
    for (int n = 0; n < 1023; n++) begin
      c[n] = g1[10] ^ g2[TAP_A[p]] ^ g2[TAP_B[p]];
      f1 = g1[3] ^ g1[10];
      f2 = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
      for (int s = 10; s > 1; s--) begin g1[s] = g1[s-1]; g2[s] = g2[s-1]; end
      g1[1] = f1;
      g2[1] = f2;
    end
    return c;
  endfunction

  function automatic int agree_at(input logic [0:1022] rx, input logic [0:1022] loc, input int ph);
    int a = 0;
    for (int k = 0; k < 1023; k++) if (rx[k] == loc[(k + ph) % 1023]) a++;
    return a;
  endfunction

  function automatic string fmt(input result_t r);
    return $sformatf("locked=%0b phase=%0d match=%0d pol=%0b",
                     r.locked, r.code_phase, r.match_count, r.polarity);
  endfunction

  // Drives one search: epochs of 1023 valid chips, then two cycles covering EVAL and SLIP/DONE.
  task automatic drive_search(input prn_t prn_sel, input logic [0:1022] tx, input int offset,
                              input bit invert, input int valid_pct, input bit gap_junk,
                              input bit flip3, input bit disturb,
                              output int epochs, output bit timed_out);
    int base = obs_q.size();
    int cyc = 0;
    epochs = 0;
    timed_out = 1'b1;
    @(posedge clk); #1;
    bus.prn = prn_sel;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int e = 0; e <= int'(TB_MAX_PHASE) + 1; e++) begin
      int k = 0;
      while (k < 1023) begin
        bus.start = disturb && (cyc == 400);
        bus.prn = (disturb && cyc >= 400) ? (prn_sel ^ 5'd1) : prn_sel;
        if (int'($urandom_range(99)) < valid_pct) begin
          bus.chip_valid = 1'b1;
          bus.chip_in = tx[(k + offset) % 1023] ^ invert ^
                        (flip3 && (k == 100 || k == 500 || k == 900));
          k++;
        end else begin
          bus.chip_valid = 1'b0;
          bus.chip_in = 1'($urandom_range(1));
        end
        @(posedge clk); #1;
        cyc++;
      end
      bus.start = 1'b0;
      epochs++;
      for (int g = 0; g < 2; g++) begin
        bus.chip_valid = gap_junk;
        bus.chip_in = 1'($urandom_range(1));
        @(posedge clk); #1;
      end
      bus.chip_valid = 1'b0;
      if (obs_q.size() > base) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.locked, bus.code_phase, bus.match_count, bus.polarity} !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%0b done=%0b %s required all zero", bus.busy, bus.done,
               fmt(result_t'{bus.locked, bus.code_phase, bus.match_count, bus.polarity}));
    end
    @(negedge clk) reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%0b done=%0b required 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_aligned;
    result_t x, o;
    int ep; bit to;
    exp_q.push_back(result_t'{1'b1, 10'd0, 11'd1023, 1'b0});
    drive_search(5'd0, code1, 0, 1'b0, 100, 1'b0, 1'b0, 1'b0, ep, to);
    x = exp_q.pop_front();
    checks++;
    if (to || obs_q.size() == 0) begin
      errors++;
      $display("FAIL aligned: no done pulse, required %s", fmt(x));
    end else begin
      o = obs_q.pop_front();
      if (o !== x) begin errors++; $display("FAIL aligned: got %s required %s", fmt(o), fmt(x)); end
    end
    checks++;
    if (ep != 1) begin errors++; $display("FAIL aligned_epochs: got %0d required 1", ep); end
  endtask

  task automatic test_offset;
    result_t x, o;
    int ep; bit to;
    exp_q.push_back(result_t'{1'b1, 10'd5, 11'd1023, 1'b0});
    drive_search(5'd0, code1, 5, 1'b0, 100, 1'b1, 1'b0, 1'b0, ep, to);
    x = exp_q.pop_front();
    checks++;
    if (to || obs_q.size() == 0) begin
      errors++;
      $display("FAIL offset: no done pulse, required %s", fmt(x));
    end else begin
      o = obs_q.pop_front();
      if (o !== x) begin errors++; $display("FAIL offset: got %s required %s", fmt(o), fmt(x)); end
    end
    checks++;
    if (ep != 6) begin errors++; $display("FAIL offset_slips: epochs %0d required 6 (5 slips)", ep); end
  endtask

  task automatic test_abort;
    result_t x, o;
    exp_q.push_back(result_t'{1'b0, 10'd0, 11'd1023, 1'b0});
    @(posedge clk); #1;
    bus.prn = 5'd0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.chip_valid = 1'b1;
    for (int k = 0; k < 300; k++) begin
      bus.chip_in = code1[k];
      @(posedge clk); #1;
    end
    bus.chip_valid = 1'b0;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.locked !== 1'b0) begin
      errors++;
      $display("FAIL abort_pulse: done=%0b busy=%0b locked=%0b required 1 1 0", bus.done, bus.busy, bus.locked);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: done=%0b busy=%0b required 0 0", bus.done, bus.busy);
    end
    x = exp_q.pop_front();
    checks++;
    if (obs_q.size() == 0) begin
      errors++;
      $display("FAIL abort_result: no done pulse, required %s", fmt(x));
    end else begin
      o = obs_q.pop_front();
      if (o !== x) begin errors++; $display("FAIL abort_result: got %s required %s", fmt(o), fmt(x)); end
    end
  endtask

  task automatic test_fail;
    result_t x, o;
    int ep; bit to;
    exp_q.push_back(result_t'{1'b0, TB_MAX_PHASE, 11'(agree_at(code2, code1, int'(TB_MAX_PHASE))), 1'b0});
    drive_search(5'd0, code2, 0, 1'b0, 100, 1'b0, 1'b0, 1'b0, ep, to);
    x = exp_q.pop_front();
    checks++;
    if (to || obs_q.size() == 0) begin
      errors++;
      $display("FAIL wrong_prn: no done pulse, required %s", fmt(x));
    end else begin
      o = obs_q.pop_front();
      if (o !== x) begin errors++; $display("FAIL wrong_prn: got %s required %s", fmt(o), fmt(x)); end
    end
    checks++;
    if (ep != int'(TB_MAX_PHASE) + 1) begin
      errors++;
      $display("FAIL wrong_prn_epochs: got %0d required %0d", ep, int'(TB_MAX_PHASE) + 1);
    end
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    bus.prn = 5'd0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.chip_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      bus.chip_in = code1[k];
      @(posedge clk); #1;
    end
    bus.chip_valid = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL mid_busy: busy=%0b required 1", bus.busy); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.locked, bus.code_phase, bus.match_count, bus.polarity} !== '0) begin
      errors++;
      $display("FAIL async_reset: busy=%0b %s required all zero", bus.busy,
               fmt(result_t'{bus.locked, bus.code_phase, bus.match_count, bus.polarity}));
    end
    @(negedge clk) reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle: busy=%0b required 0", bus.busy); end
  endtask

  task automatic test_noisy;
    result_t x, o;
    int ep; bit to;
    exp_q.push_back(result_t'{1'b1, 10'd0, 11'd1020, 1'b0});
    drive_search(5'd0, code1, 0, 1'b0, 50, 1'b0, 1'b1, 1'b1, ep, to);
    x = exp_q.pop_front();
    checks++;
    if (to || obs_q.size() == 0) begin
      errors++;
      $display("FAIL noisy: no done pulse, required %s", fmt(x));
    end else begin
      o = obs_q.pop_front();
      if (o !== x) begin errors++; $display("FAIL noisy: got %s required %s", fmt(o), fmt(x)); end
    end
  endtask

  task automatic test_other_prn;
    result_t x, o;
    int ep; bit to;
    exp_q.push_back(result_t'{1'b1, 10'd2, 11'd1023, 1'b0});
    drive_search(5'd9, code10, 2, 1'b0, 100, 1'b0, 1'b0, 1'b0, ep, to);
    x = exp_q.pop_front();
    checks++;
    if (to || obs_q.size() == 0) begin
      errors++;
      $display("FAIL prn10: no done pulse, required %s", fmt(x));
    end else begin
      o = obs_q.pop_front();
      if (o !== x) begin errors++; $display("FAIL prn10: got %s required %s", fmt(o), fmt(x)); end
    end
  endtask

  task automatic test_inverted;
    result_t x, o;
    int ep; bit to;
`ifdef CA_CHECKER_INVERT_EN
    exp_q.push_back(result_t'{1'b1, 10'd0, 11'd0, 1'b1});
`else
    exp_q.push_back(result_t'{1'b0, TB_MAX_PHASE, 11'(agree_at(~code1, code1, int'(TB_MAX_PHASE))), 1'b0});
`endif
    drive_search(5'd0, code1, 0, 1'b1, 100, 1'b0, 1'b0, 1'b0, ep, to);
    x = exp_q.pop_front();
    checks++;
    if (to || obs_q.size() == 0) begin
      errors++;
      $display("FAIL inverted: no done pulse, required %s", fmt(x));
    end else begin
      o = obs_q.pop_front();
      if (o !== x) begin errors++; $display("FAIL inverted: got %s required %s", fmt(o), fmt(x)); end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.prn = 5'd0;
    bus.chip_in = 1'b0;
    bus.chip_valid = 1'b0;
    code1  = gen_code(0);
    code2  = gen_code(1);
    code10 = gen_code(9);
    repeat (3) @(posedge clk);

    test_reset();
    test_aligned();
    test_offset();
    test_abort();
    test_fail();
    test_reset_mid();
    test_noisy();
    test_other_prn();
    test_inverted();

    checks++;
    if (obs_q.size() != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: unmatched done pulses=%0d expected entries=%0d required 0 0",
               obs_q.size(), exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
